id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 24 ++
 rtl/id_ex_stage_load_use_detector.sv | 38 +++
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register slice:
//   - data_dest_e : writeback source select carried with each instruction
//   - state_e     : ID/EX control FSM states
//   - REG_ADDR_W  : architectural register address width
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        DEST_ALU = 2'd0,
        DEST_MEM = 2'd1,
        DEST_PC  = 2'd2
    } data_dest_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_HOLD       = 2'd2
    } state_e;

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// -----------------------------------------------------------------------------
// id_ex_stage_load_use_detector
// Pure combinational load-use hazard compare between the instruction in EX and
// the instruction sitting in ID.
//   ex_valid_i / ex_reg_wr_sig_i / ex_data_dest_i / ex_reg_wr_addr_i : EX side
//   id_valid_i / id_rs{1,2}_used_i / id_reg_addr{1,2}_i             : ID side
//   load_use_o : EX is a load to a non-zero register that ID reads
// -----------------------------------------------------------------------------
module id_ex_stage_load_use_detector
    import id_ex_stage_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_reg_wr_sig_i,
    input  logic [1:0]            ex_data_dest_i,
    input  logic [REG_ADDR_W-1:0] ex_reg_wr_addr_i,
    input  logic                  id_valid_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_reg_addr1_i,
    input  logic [REG_ADDR_W-1:0] id_reg_addr2_i,
    output logic                  load_use_o
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real destination, so a load to x0 cannot create a hazard.
    assign ex_is_load = ex_valid_i & ex_reg_wr_sig_i
                      & (ex_data_dest_i == DEST_MEM)
                      & (ex_reg_wr_addr_i != '0);

    assign rs1_hit = id_rs1_used_i & (id_reg_addr1_i == ex_reg_wr_addr_i);
    assign rs2_hit = id_rs2_used_i & (id_reg_addr2_i == ex_reg_wr_addr_i);

    assign load_use_o = ex_is_load & id_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall, EX back-pressure hold and
// branch flush, plus a saturating stall-cycle counter.
//   clk_i, rst_i          : clock, async active-high reset
//   id_*_i                : decoded instruction from ID (operands pre-forwarded)
//   flush_i               : squash the ID instruction (taken branch/jump in EX)
//   ex_busy_i             : EX cannot accept a new instruction this cycle
//   stall_o               : freeze PC and IF/ID (combinational)
//   ex_*_o                : registered instruction presented to EX
//   stall_cnt_o           : saturating count of cycles with stall_o=1
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_reg_addr1_i,
    input  logic [REG_ADDR_W-1:0] id_reg_addr2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [XLEN-1:0]       id_rs1_i,
    input  logic [XLEN-1:0]       id_rs2_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [REG_ADDR_W-1:0] id_reg_wr_addr_i,
    input  logic                  id_reg_wr_sig_i,
    input  logic [1:0]            id_data_dest_i,
    input  logic [3:0]            id_alu_op_i,

    input  logic                  flush_i,
    input  logic                  ex_busy_i,

    output logic                  stall_o,

    output logic                  ex_valid_o,
    output logic [REG_ADDR_W-1:0] ex_reg_wr_addr_o,
    output logic                  ex_reg_wr_sig_o,
    output logic [1:0]            ex_data_dest_o,
    output logic [3:0]            ex_alu_op_o,
    output logic [XLEN-1:0]       ex_rs1_o,
    output logic [XLEN-1:0]       ex_rs2_o,
    output logic [XLEN-1:0]       ex_imm_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [XLEN-1:0]       ex_pc_plus4_o,

    output logic [CNT_W-1:0]      stall_cnt_o
);

    state_e                state_q;
    state_e                state_d;

    logic                  ex_valid_q;
    logic [REG_ADDR_W-1:0] ex_reg_wr_addr_q;
    logic                  ex_reg_wr_sig_q;
    logic [1:0]            ex_data_dest_q;
    logic [3:0]            ex_alu_op_q;
    logic [XLEN-1:0]       ex_rs1_q;
    logic [XLEN-1:0]       ex_rs2_q;
    logic [XLEN-1:0]       ex_imm_q;
    logic [XLEN-1:0]       ex_pc_q;
    logic [XLEN-1:0]       ex_pc_plus4_q;
    logic [CNT_W-1:0]      stall_cnt_q;

    logic                  load_use;
    logic                  hold_d;
    logic                  bubble_d;

    id_ex_stage_load_use_detector u_load_use_detector (
        .ex_valid_i       (ex_valid_q),
        .ex_reg_wr_sig_i  (ex_reg_wr_sig_q),
        .ex_data_dest_i   (ex_data_dest_q),
        .ex_reg_wr_addr_i (ex_reg_wr_addr_q),
        .id_valid_i       (id_valid_i),
        .id_rs1_used_i    (id_rs1_used_i),
        .id_rs2_used_i    (id_rs2_used_i),
        .id_reg_addr1_i   (id_reg_addr1_i),
        .id_reg_addr2_i   (id_reg_addr2_i),
        .load_use_o       (load_use)
    );

    // Per-cycle decision: flush beats busy beats load-use. HOLD re-evaluates
    // exactly like RUN once busy drops. LOAD_STALL always releases the ID
    // instruction since the loaded value is forwarded from EX/MEM by then.
    always_comb begin
        stall_o  = 1'b0;
        hold_d   = 1'b0;
        bubble_d = 1'b0;
        state_d  = ST_RUN;
        if (flush_i) begin
            bubble_d = 1'b1;
        end else if (ex_busy_i) begin
            stall_o = 1'b1;
            hold_d  = 1'b1;
            state_d = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (load_use) begin
                        stall_o  = 1'b1;
                        bubble_d = 1'b1;
                        state_d  = ST_LOAD_STALL;
                    end else begin
                        bubble_d = ~id_valid_i;
                    end
                end
                ST_LOAD_STALL: begin
                    bubble_d = ~id_valid_i;
                end
                default: begin
                    bubble_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_RUN;
            ex_valid_q       <= 1'b0;
            ex_reg_wr_addr_q <= '0;
            ex_reg_wr_sig_q  <= 1'b0;
            ex_data_dest_q   <= '0;
            ex_alu_op_q      <= '0;
            ex_rs1_q         <= '0;
            ex_rs2_q         <= '0;
            ex_imm_q         <= '0;
            ex_pc_q          <= '0;
            ex_pc_plus4_q    <= '0;
            stall_cnt_q      <= '0;
        end else begin
            state_q <= state_d;

            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            if (!hold_d) begin
                if (bubble_d) begin
                    ex_valid_q       <= 1'b0;
                    ex_reg_wr_addr_q <= '0;
                    ex_reg_wr_sig_q  <= 1'b0;
                    ex_data_dest_q   <= '0;
                    ex_alu_op_q      <= '0;
                    ex_rs1_q         <= '0;
                    ex_rs2_q         <= '0;
                    ex_imm_q         <= '0;
                    ex_pc_q          <= '0;
                    ex_pc_plus4_q    <= '0;
                end else begin
                    ex_valid_q       <= 1'b1;
                    ex_reg_wr_addr_q <= id_reg_wr_addr_i;
                    // A write to x0 is dropped here so downstream never sees it.
                    ex_reg_wr_sig_q  <= id_reg_wr_sig_i & (id_reg_wr_addr_i != '0);
                    ex_data_dest_q   <= id_data_dest_i;
                    ex_alu_op_q      <= id_alu_op_i;
                    ex_rs1_q         <= id_rs1_i;
                    ex_rs2_q         <= id_rs2_i;
                    ex_imm_q         <= id_imm_i;
                    ex_pc_q          <= id_pc_i;
                    ex_pc_plus4_q    <= id_pc_i + XLEN'(4);
                end
            end
        end
    end

    assign ex_valid_o       = ex_valid_q;
    assign ex_reg_wr_addr_o = ex_reg_wr_addr_q;
    assign ex_reg_wr_sig_o  = ex_reg_wr_sig_q;
    assign ex_data_dest_o   = ex_data_dest_q;
    assign ex_alu_op_o      = ex_alu_op_q;
    assign ex_rs1_o         = ex_rs1_q;
    assign ex_rs2_o         = ex_rs2_q;
    assign ex_imm_o         = ex_imm_q;
    assign ex_pc_o          = ex_pc_q;
    assign ex_pc_plus4_o    = ex_pc_plus4_q;
    assign stall_cnt_o      = stall_cnt_q;

endmodule
